// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter and the control unit
// that names its writeback sources.
package regfile_write_arbiter_pkg;

  localparam int unsigned WIDTH_DEF      = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned NUM_REQ_DEF    = 3;
  localparam int unsigned DROP_W         = 8;

  // Register 0 is hard-wired; writes to it are accepted but discarded
  localparam int unsigned REG_ZERO = 0;

  // Writeback source indices used by the control unit
  localparam int unsigned WB_ALU  = 0;
  localparam int unsigned WB_MEM  = 1;
  localparam int unsigned WB_LINK = 2;

  // Index width that stays legal for a single requester
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin priority picker: grants the first valid requester at or after
// the pointer, and moves the pointer past the winner when told a transfer happened.
module regfile_write_arbiter_rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               upd_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] low_mask_c;
  logic [NUM_REQ-1:0] cand_c;

  // Prefer requesters at or above the pointer; fall back to the wrapped set
  always_comb begin
    low_mask_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      low_mask_c[IDX_W'(i)] = (IDX_W'(i) < ptr_q);
    end
    cand_c = ((valid_i & ~low_mask_c) != '0) ? (valid_i & ~low_mask_c) : valid_i;
    if (!en_i) begin
      cand_c = '0;
    end
    idx_o = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (cand_c[IDX_W'(i)]) begin
        idx_o = IDX_W'(i);
      end
    end
    any_o   = |cand_c;
    grant_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i && any_o) begin
      ptr_d = (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback sources
// with round-robin grants, a registered output stage and a pending-write mask.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          regWrite,
  output logic [ADDR_WIDTH-1:0]         writeAddr,
  output logic [WIDTH-1:0]              writeData,
  output logic [(1<<ADDR_WIDTH)-1:0]    pending,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned NREG  = 1 << ADDR_WIDTH;

  logic                  arb_en_c;
  logic [NUM_REQ-1:0]    grant_c;
  logic [IDX_W-1:0]      gnt_idx_c;
  logic                  gnt_any_c;
  logic                  hs_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [WIDTH-1:0]      sel_data_c;
  logic [NREG-1:0]       pending_c;

  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [WIDTH-1:0]      write_data_q, write_data_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

  // Grants are suppressed while reset is held, not only after it is sampled
  assign arb_en_c = en & ~reset;

  regfile_write_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .en_i    (arb_en_c),
    .valid_i (req_valid),
    .upd_i   (hs_c),
    .grant_o (grant_c),
    .idx_o   (gnt_idx_c),
    .any_o   (gnt_any_c)
  );

  assign req_ready = grant_c;
  assign hs_c      = gnt_any_c & (|(req_valid & grant_c));

  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_idx_c == IDX_W'(i)) begin
        sel_addr_c = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_c = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: capture the winner; address/data hold when idle
  always_comb begin
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    drop_cnt_d   = drop_cnt_q;
    if (hs_c) begin
      write_addr_d = sel_addr_c;
      write_data_d = sel_data_c;
      reg_write_d  = (sel_addr_c != ADDR_WIDTH'(REG_ZERO));
      if ((sel_addr_c == ADDR_WIDTH'(REG_ZERO)) && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Writes in flight: requests still waiting plus the one on the port
  always_comb begin
    pending_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[IDX_W'(i)]) begin
        pending_c[req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
    end
    if (reg_write_q) begin
      pending_c[write_addr_q] = 1'b1;
    end
    pending_c[ADDR_WIDTH'(REG_ZERO)] = 1'b0;
  end

  assign regWrite   = reg_write_q;
  assign writeAddr  = write_addr_q;
  assign writeData  = write_data_q;
  assign pending    = pending_c;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random
// traffic against a round-robin/queue-free reference model.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int N    = 3;
  localparam int W    = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            regWrite;
  logic [AW-1:0]   writeAddr;
  logic [W-1:0]    writeData;
  logic [NREG-1:0] pending;
  logic [7:0]      drop_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            m_ptr;
  logic          m_rw;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;
  int            m_drop;
  logic [N-1:0]  m_last_g;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .regWrite   (regWrite),
    .writeAddr  (writeAddr),
    .writeData  (writeData),
    .pending    (pending),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [AW-1:0] addr_of(input int j);
    logic [N*AW-1:0] a;
    a = req_addr >> (j * AW);
    return a[AW-1:0];
  endfunction

  function automatic logic [W-1:0] data_of(input int j);
    logic [N*W-1:0] d;
    d = req_data >> (j * W);
    return d[W-1:0];
  endfunction

  function automatic logic valid_of(input int j);
    logic [N-1:0] v;
    v = req_valid >> j;
    return v[0];
  endfunction

  // Walk requesters from the pointer, wrapping; first valid one wins
  function automatic logic [N-1:0] exp_ready();
    int j;
    if (reset || !en) return '0;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (valid_of(j)) return N'(1) << j;
    end
    return '0;
  endfunction

  function automatic logic [NREG-1:0] exp_pending();
    logic [NREG-1:0] p;
    p = '0;
    for (int j = 0; j < N; j++)
      if (valid_of(j)) p = p | (NREG'(1) << addr_of(j));
    if (m_rw) p = p | (NREG'(1) << m_addr);
    p = p & ~NREG'(1);
    return p;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid = (req_valid & ~(N'(1) << i)) | (N'(v) << i);
    req_addr  = (req_addr & ~((N*AW)'({AW{1'b1}}) << (i*AW))) | ((N*AW)'(a) << (i*AW));
    req_data  = (req_data & ~((N*W)'({W{1'b1}}) << (i*W))) | ((N*W)'(d) << (i*W));
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_rw     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_drop   = 0;
    m_last_g = '0;
  endtask

  // One rising edge; the model applies the same handshake the inputs imply
  task automatic tick();
    logic [N-1:0] g;
    g = exp_ready();
    @(posedge clk);
    m_last_g = g;
    if (g != '0) begin
      for (int j = 0; j < N; j++) begin
        if (((g >> j) & N'(1)) != '0) begin
          m_addr = addr_of(j);
          m_data = data_of(j);
          m_rw   = (m_addr != '0);
          if (m_addr == '0 && m_drop < 255) m_drop++;
          m_ptr  = (j + 1) % N;
        end
      end
    end else begin
      m_rw = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    en        = 1'b1;
    req_valid = '1;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = '0;
    model_reset();
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    @(posedge clk); #1;
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", regWrite); end
    checks++; if (writeAddr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", writeAddr); end
    checks++; if (writeData !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", writeData); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = '0;
    en = 1'b1;
    set_req(WB_MEM, 1'b1, 5'd8, 32'hdeadbeef);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b want 010", req_ready); end
    checks++; if (pending !== (NREG'(1) << 8)) begin errors++; $display("FAIL single_pending: got %h want %h", pending, NREG'(1) << 8); end
    tick();
    checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL single_rw: got %b want 1", regWrite); end
    checks++; if (writeAddr !== 5'd8) begin errors++; $display("FAIL single_addr: got %0d want 8", writeAddr); end
    checks++; if (writeData !== 32'hdeadbeef) begin errors++; $display("FAIL single_data: got %h want deadbeef", writeData); end
    @(negedge clk);
    req_valid = '0;
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL single_rw_off: got %b want 0", regWrite); end
    checks++; if (writeAddr !== 5'd8) begin errors++; $display("FAIL single_addr_hold: got %0d want 8", writeAddr); end
  endtask

  task automatic test_contention();
    int c;
    do_reset();
    en = 1'b1;
    set_req(WB_ALU,  1'b1, 5'd9,  32'h0000_0009);
    set_req(WB_MEM,  1'b1, 5'd10, 32'h0000_000a);
    set_req(WB_LINK, 1'b1, 5'd11, 32'h0000_000b);
    for (c = 0; c < 6; c++) begin
      #1;
      checks++; if (req_ready !== (N'(1) << (c % 3))) begin errors++; $display("FAIL contend_grant[%0d]: got %b want %b", c, req_ready, N'(1) << (c % 3)); end
      tick();
      checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL contend_rw[%0d]: got %b want 1", c, regWrite); end
      checks++; if (writeAddr !== AW'(9 + c % 3)) begin errors++; $display("FAIL contend_addr[%0d]: got %0d want %0d", c, writeAddr, 9 + c % 3); end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_zero_reg();
    do_reset();
    en = 1'b1;
    set_req(WB_ALU, 1'b1, 5'd0, 32'd5);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL zero_ready[%0d]: got %b want 001", c, req_ready); end
      tick();
      checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL zero_rw[%0d]: got %b want 0", c, regWrite); end
      @(negedge clk);
    end
    checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL zero_drop3: got %0d want 3", drop_count); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL zero_pending: got %h want 0", pending); end
    for (int c = 0; c < 300; c++) tick();
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL zero_drop_sat: got %0d want 255", drop_count); end
    checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL zero_drop_model: got %0d want %0d", drop_count, m_drop); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_pending_en();
    @(negedge clk);
    req_valid = '0;
    en = 1'b0;
    set_req(WB_LINK, 1'b1, 5'd12, 32'h1234_5678);
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL pend_ready_dis: got %b want 000", req_ready); end
    checks++; if (pending !== (NREG'(1) << 12)) begin errors++; $display("FAIL pend_req: got %h want %h", pending, NREG'(1) << 12); end
    tick();
    checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL pend_rw_dis: got %b want 0", regWrite); end
    @(negedge clk);
    en = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL pend_ready_en: got %b want 100", req_ready); end
    tick();
    checks++; if (regWrite !== 1'b1 || writeAddr !== 5'd12) begin errors++; $display("FAIL pend_write: got rw=%b addr=%0d want rw=1 addr=12", regWrite, writeAddr); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (pending !== (NREG'(1) << 12)) begin errors++; $display("FAIL pend_stage: got %h want %h", pending, NREG'(1) << 12); end
    tick();
    checks++; if (pending !== '0) begin errors++; $display("FAIL pend_clear: got %h want 0", pending); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!valid_of(i) || ((m_last_g >> i) & N'(1)) != '0) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, 1'b1, AW'($urandom_range(0, NREG - 1)), $urandom);
          else
            set_req(i, 1'b0, '0, '0);
        end
      end
      en = ($urandom_range(0, 7) != 0);
      #1;
      checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_ready()); end
      checks++; if (pending !== exp_pending()) begin errors++; $display("FAIL rand_pending[%0d]: got %h want %h", c, pending, exp_pending()); end
      tick();
      checks++; if (regWrite !== m_rw || writeAddr !== m_addr || writeData !== m_data) begin
        errors++;
        $display("FAIL rand_port[%0d]: got rw=%b a=%0d d=%h want rw=%b a=%0d d=%h", c, regWrite, writeAddr, writeData, m_rw, m_addr, m_data);
      end
      checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL rand_drop[%0d]: got %0d want %0d", c, drop_count, m_drop); end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    set_req(WB_ALU,  1'b1, 5'd0,  32'h0000_00a0);
    set_req(WB_MEM,  1'b1, 5'd10, 32'h0000_00a1);
    set_req(WB_LINK, 1'b1, 5'd11, 32'h0000_00a2);
    tick();
    tick();
    checks++; if (regWrite !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL arst_pre: got rw=%b drop=%0d want rw=1 drop=1", regWrite, drop_count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (regWrite !== 1'b0 || writeAddr !== '0 || writeData !== '0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL arst_clear: got rw=%b a=%0d d=%h drop=%0d want all 0", regWrite, writeAddr, writeData, drop_count);
    end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL arst_ready: got %b want 000", req_ready); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL arst_ptr: got %b want 001", req_ready); end
    tick();
    checks++; if (regWrite !== 1'b0 || writeData !== 32'h0000_00a0 || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL arst_after: got rw=%b d=%h drop=%0d want rw=0 d=000000a0 drop=1", regWrite, writeData, drop_count);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_reg();
    test_pending_en();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
